// File: rtl/dac_spi_if.sv
// dac_spi_if: load/status handshake and SPI pins between the sample source and the DAC transmitter.
interface dac_spi_if;
  logic [9:0] data_in;
  logic       load;
  logic       busy;
  logic       overrun;
  logic       dac_cs_n;
  logic       dac_sck;
  logic       dac_sdi;
  logic       dac_ld_n;
  modport master (
    output data_in, load,
    input  busy, overrun, dac_cs_n, dac_sck, dac_sdi, dac_ld_n
  );
  modport slave (
    input  data_in, load,
    output busy, overrun, dac_cs_n, dac_sck, dac_sdi, dac_ld_n
  );
endinterface

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: sends one 16-bit DAC command frame per accepted load, then pulses ld_n to latch it.
module dac_spi_tx #(
  parameter int   CLK_DIV = 25,
  parameter logic BUF     = 1'b1,
  parameter logic GA_N    = 1'b1
) (
  input  logic sysclk,
  input  logic rst_n,
  dac_spi_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LATCH} state_e;
  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] sr_q, sr_d;
  logic        sck_q, sck_d;
  logic        ovr_q, ovr_d;
  logic        busy, tick;
  assign busy = state_q != IDLE;
  assign tick = busy && div_q == 8'(CLK_DIV - 1);
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      sck_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sck_q   <= sck_d;
      ovr_q   <= ovr_d;
    end
  end
  // divider is held at 0 in IDLE so every frame starts with a full SETUP period
  always_comb begin
    state_d = state_q;
    div_d   = (busy && !tick) ? div_q + 8'd1 : '0;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sck_d   = sck_q;
    ovr_d   = bus.load && busy;
    case (state_q)
      IDLE: if (bus.load) begin
        sr_d    = {1'b0, BUF, GA_N, 1'b1, bus.data_in, 2'b00};
        bit_d   = '0;
        sck_d   = 1'b0;
        state_d = SETUP;
      end
      SETUP: state_d = tick ? SHIFT : SETUP;
      SHIFT: if (tick) begin
        sck_d   = ~sck_q;
        bit_d   = bit_q + 5'd1;
        sr_d    = sck_q ? {sr_q[14:0], 1'b0} : sr_q;
        state_d = (bit_q == 5'd31) ? HOLD : SHIFT;
      end
      HOLD:    state_d = tick ? LATCH : HOLD;
      LATCH:   state_d = tick ? IDLE : LATCH;
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy     = busy;
  assign bus.overrun  = ovr_q;
  assign bus.dac_cs_n = state_q == IDLE || state_q == LATCH;
  assign bus.dac_sck  = sck_q;
  assign bus.dac_sdi  = busy & sr_q[15];
  assign bus.dac_ld_n = state_q != LATCH;
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: per-cycle reference model plus frame scoreboard for dac_spi_tx at CLK_DIV=2.
module tb_dac_spi_tx;
  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 sysclk = ~sysclk;
  dac_spi_if bus();
  dac_spi_tx #(.CLK_DIV(2)) dut (.sysclk(sysclk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] frame_of(logic [9:0] d);
    return {1'b0, 1'b1, 1'b1, 1'b1, d, 2'b00};
  endfunction
  int          m_cnt = 0;
  logic        m_ovr = 1'b0;
  logic [15:0] q[$];
  int          starts[$];
  logic [15:0] cap = '0;
  logic [15:0] last_frame = '0;
  int          nbits = 0;
  int          frames = 0;
  int          cyc = 0;
  logic        p_sck = 1'b0, p_cs = 1'b1, p_ld = 1'b1;
  // Outputs are sampled on the falling edge; the model then predicts the next rising edge.
  always @(negedge sysclk) begin
    int c;
    c = 71 - m_cnt;
    cyc++;
    chk("busy", bus.busy, m_cnt > 0);
    chk("overrun", bus.overrun, m_ovr);
    chk("cs_n", bus.dac_cs_n, !(m_cnt > 2));
    chk("ld_n", bus.dac_ld_n, !(m_cnt == 1 || m_cnt == 2));
    chk("sck", bus.dac_sck, m_cnt > 0 && c >= 5 && c <= 66 && ((c - 5) % 4 < 2));
    if (p_cs && !bus.dac_cs_n) begin
      nbits = 0;
      starts.push_back(cyc);
    end
    if (!p_sck && bus.dac_sck) begin
      cap = {cap[14:0], bus.dac_sdi};
      nbits++;
    end
    if (p_ld && !bus.dac_ld_n) begin
      frames++;
      last_frame = cap;
      chk("nbits", nbits, 16);
      chk("sb_depth", q.size(), 1);
      if (q.size() > 0) chk("sb_frame", cap, q.pop_front());
    end
    p_sck = bus.dac_sck;
    p_cs  = bus.dac_cs_n;
    p_ld  = bus.dac_ld_n;
    if (!rst_n) begin
      m_cnt = 0;
      m_ovr = 1'b0;
      q.delete();
    end else begin
      m_ovr = bus.load && m_cnt > 0;
      if (m_cnt > 0) m_cnt--;
      else if (bus.load) begin
        m_cnt = 70;
        q.push_back(frame_of(bus.data_in));
      end
    end
  end
  typedef struct {
    logic [9:0]  d;
    logic [15:0] exp;
  } vec_t;
  vec_t tv[5];
  task automatic send(logic [9:0] d);
    @(posedge sysclk); #1;
    bus.data_in = d;
    bus.load    = 1'b1;
    @(posedge sysclk); #1;
    bus.load    = 1'b0;
  endtask
  task automatic wait_frame(int target);
    for (int i = 0; i < 400 && frames < target; i++) @(posedge sysclk);
    #1;
    chk("frame_done", frames, target);
  endtask
  initial begin
    int f;
    bus.load    = 1'b0;
    bus.data_in = '0;
    tv = '{'{10'h3FF, 16'h7FFC}, '{10'h200, 16'h7800}, '{10'h000, 16'h7000},
           '{10'h155, 16'h7554}, '{10'h0AA, 16'h72A8}};
    repeat (3) @(posedge sysclk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(tv[i].d);
      wait_frame(i + 1);
      chk("tv_frame", last_frame, tv[i].exp);
      repeat (4) @(posedge sysclk);
    end
    // load during frame: rejected, overrun on the following cycle
    f = frames;
    send(10'h3FF);
    repeat (9) @(posedge sysclk);
    #1;
    bus.data_in = 10'h000;
    bus.load    = 1'b1;
    @(posedge sysclk); #1;
    bus.load    = 1'b0;
    chk("overrun_pulse", bus.overrun, 1);
    wait_frame(f + 1);
    chk("overrun_frame", last_frame, 16'h7FFC);
    repeat (80) @(posedge sysclk);
    chk("no_second_frame", frames, f + 1);
    // data_in changes after capture
    send(10'h3FF);
    bus.data_in = 10'h000;
    wait_frame(f + 2);
    chk("data_change", last_frame, 16'h7FFC);
    repeat (4) @(posedge sysclk);
    // reset during the 5th sck pulse
    f = frames;
    send(10'h2AB);
    repeat (20) @(posedge sysclk);
    #1;
    chk("sck_pulse5", bus.dac_sck, 1);
    rst_n = 1'b0;
    @(posedge sysclk); #1;
    rst_n = 1'b1;
    chk("abort_cs_n", bus.dac_cs_n, 1);
    chk("abort_sck", bus.dac_sck, 0);
    chk("abort_busy", bus.busy, 0);
    repeat (80) @(posedge sysclk);
    chk("abort_no_latch", frames, f);
    send(10'h12F);
    wait_frame(f + 1);
    chk("after_reset", last_frame, 16'h74BC);
    repeat (4) @(posedge sysclk);
    // load held high: back-to-back frames
    f = frames;
    starts.delete();
    @(posedge sysclk); #1;
    bus.data_in = 10'h155;
    bus.load    = 1'b1;
    wait_frame(f + 3);
    bus.load = 1'b0;
    chk("held_frame", last_frame, 16'h7554);
    repeat (80) @(posedge sysclk);
    if (starts.size() < 3) chk("held_starts", starts.size(), 3);
    else begin
      chk("period_1", starts[1] - starts[0], 71);
      chk("period_2", starts[2] - starts[1], 71);
    end
    chk("sb_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
